// File: rtl/trace_sequencer_if.sv
// rtl/trace_sequencer_if.sv - acquisition/display bus of the trace sequencer
interface trace_sequencer_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic          arm;
    logic          sample_en;
    logic [1:0]    probe;
    logic [10:0]   x;
    logic [9:0]    y;
    logic [1:0]    state;
    logic          change;
    logic [AW-1:0] col_idx;
    logic          col_valid;
    logic [1:0]    fsm;

    modport master (
        output arm, sample_en, probe, x, y,
        input  state, change, col_idx, col_valid, fsm
    );

    modport slave (
        input  arm, sample_en, probe, x, y,
        output state, change, col_idx, col_valid, fsm
    );
endinterface

// File: rtl/trace_sequencer.sv
// rtl/trace_sequencer.sv - triggered 2-bit probe capture with per-column trace readout
module trace_sequencer #(
    parameter int          DEPTH = 64,
    parameter logic [10:0] PX    = 11'd10,
    parameter logic [10:0] BX    = 11'd10
) (
    input  logic              clk,
    input  logic              rst,
    trace_sequencer_if.slave  bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] HALF     = AW'(DEPTH / 2);
    localparam logic [AW-1:0] HALF_M1  = AW'(DEPTH / 2 - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [5:0]    SUB_MAX  = 6'(BX - 11'd1);
    localparam logic [31:0]   AREA_END = 32'(PX) + 32'(DEPTH) * 32'(BX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_HOLD    = 2'b11
    } fsm_t;

    fsm_t          fsm_q;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rd_base_q;
    logic [AW-1:0] pre_cnt_q;
    logic [AW-1:0] post_cnt_q;
    logic [1:0]    last_code_q;
    logic [5:0]    sub_q, sub_d;
    logic [AW-1:0] col_q, col_d;
    logic [1:0]    state_q;
    logic          change_q;
    logic [AW-1:0] col_idx_q;
    logic          col_valid_q;

    logic          wr_en;
    logic          is_change;
    logic          in_area;
    logic          show_d;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_word;
    logic [31:0]   x_ext;

    assign wr_en     = bus.sample_en && (fsm_q == S_ARMED || fsm_q == S_CAPTURE);
    assign is_change = (bus.probe != last_code_q);
    assign x_ext     = {21'd0, bus.x};
    assign in_area   = (x_ext >= 32'(PX)) && (x_ext < AREA_END);
    // A pending arm leaves HOLD on this edge, so the display blanks together with the state change.
    assign show_d    = (fsm_q == S_HOLD) && !bus.arm && in_area && (bus.y != 10'h3FF);
    assign rd_addr   = rd_base_q + col_d;
    assign rd_word   = mem_q[rd_addr];

    // Acquisition state machine: pre/post-trigger counting, write pointer and hold base.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            wp_q        <= '0;
            rd_base_q   <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            last_code_q <= 2'b00;
        end else begin
            if (wr_en) begin
                wp_q        <= wp_q + ONE;
                last_code_q <= bus.probe;
            end
            unique case (fsm_q)
                S_IDLE: begin
                    if (bus.arm) begin
                        fsm_q      <= S_ARMED;
                        pre_cnt_q  <= '0;
                        post_cnt_q <= '0;
                    end
                end
                S_ARMED: begin
                    if (wr_en) begin
                        if (pre_cnt_q == HALF && is_change) begin
                            fsm_q      <= S_CAPTURE;
                            post_cnt_q <= ONE;
                        end else if (pre_cnt_q != HALF) begin
                            pre_cnt_q <= pre_cnt_q + ONE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (wr_en) begin
                        post_cnt_q <= post_cnt_q + ONE;
                        if (post_cnt_q == HALF_M1) begin
                            fsm_q     <= S_HOLD;
                            rd_base_q <= wp_q + ONE;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.arm) begin
                        fsm_q      <= S_ARMED;
                        pre_cnt_q  <= '0;
                        post_cnt_q <= '0;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    // Sample ring: each entry keeps the code plus whether it differs from the previous sample.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wp_q] <= {is_change, bus.probe};
        end
    end

    // Column of the current x, derived from the previous column since x advances by one per clock.
    always_comb begin
        sub_d = sub_q + 6'd1;
        col_d = col_q;
        if (bus.x == PX) begin
            sub_d = '0;
            col_d = '0;
        end else if (sub_q == SUB_MAX) begin
            sub_d = '0;
            col_d = col_q + ONE;
        end
    end

    // Column counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= '0;
            col_q <= '0;
        end else begin
            sub_q <= sub_d;
            col_q <= col_d;
        end
    end

    // Registered display outputs, one clock behind x.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= 2'b00;
            change_q    <= 1'b0;
            col_idx_q   <= '0;
            col_valid_q <= 1'b0;
        end else begin
            col_idx_q   <= col_d;
            col_valid_q <= show_d;
            state_q     <= show_d ? rd_word[1:0] : 2'b00;
            change_q    <= (show_d && col_d != '0) ? rd_word[2] : 1'b0;
        end
    end

    assign bus.state     = state_q;
    assign bus.change    = change_q;
    assign bus.col_idx   = col_idx_q;
    assign bus.col_valid = col_valid_q;
    assign bus.fsm       = fsm_q;
endmodule

// File: tb/tb_trace_sequencer.sv
// tb/tb_trace_sequencer.sv - self-checking bench for trace_sequencer
module tb_trace_sequencer;
    localparam int DEPTH = 64;
    localparam int PX    = 10;
    localparam int BX    = 10;
    localparam int HALF  = DEPTH / 2;
    localparam int XEND  = PX + DEPTH * BX;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trace_sequencer_if #(.DEPTH(DEPTH)) bus ();

    trace_sequencer #(.DEPTH(DEPTH), .PX(11'd10), .BX(11'd10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int         m_fsm;
    int         m_wp;
    int         m_rd;
    int         m_pre_writes;
    int         m_post_writes;
    logic [1:0] m_last;
    logic [1:0] m_code [DEPTH];
    bit         m_live = 1'b0;

    int exp_fsm, exp_state, exp_change, exp_valid, exp_col;
    bit exp_col_chk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  nf;
        bit  wr;
        bit  vis;
        int  col;
        int  a;
        int  xi;
        int  yi;
        xi = int'(bus.x);
        yi = int'(bus.y);
        m_live = 1'b1;
        if (rst) begin
            m_fsm = 0; m_wp = 0; m_rd = 0; m_pre_writes = 0; m_post_writes = 0; m_last = 2'b00;
            exp_fsm = 0; exp_state = 0; exp_change = 0; exp_valid = 0; exp_col = 0; exp_col_chk = 1'b1;
            return;
        end
        nf = m_fsm;
        wr = bus.sample_en && (m_fsm == 1 || m_fsm == 2);
        if (m_fsm == 0 || m_fsm == 3) begin
            if (bus.arm) begin
                nf = 1;
                m_pre_writes = 0;
            end
        end else if (m_fsm == 1 && wr) begin
            if (m_pre_writes >= HALF && bus.probe != m_last) begin
                nf = 2;
                m_post_writes = 1;
            end else begin
                m_pre_writes++;
            end
        end else if (m_fsm == 2 && wr) begin
            m_post_writes++;
            if (m_post_writes == HALF) begin
                nf = 3;
                m_rd = (m_wp + 1) % DEPTH;
            end
        end
        if (wr) begin
            m_code[m_wp] = bus.probe;
            m_last = bus.probe;
            m_wp = (m_wp + 1) % DEPTH;
        end
        vis = (m_fsm == 3) && (nf == 3) && (xi >= PX) && (xi < XEND) && (yi != 10'h3FF);
        if (vis) begin
            col        = (xi - PX) / BX;
            a          = (m_rd + col) % DEPTH;
            exp_state  = int'(m_code[a]);
            exp_change = (col > 0 && m_code[a] != m_code[(a + DEPTH - 1) % DEPTH]) ? 1 : 0;
            exp_valid  = 1;
            exp_col    = col;
            exp_col_chk = 1'b1;
        end else begin
            exp_state = 0; exp_change = 0; exp_valid = 0; exp_col_chk = 1'b0;
        end
        m_fsm   = nf;
        exp_fsm = nf;
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("fsm", int'(bus.fsm), exp_fsm);
            chk("state", int'(bus.state), exp_state);
            chk("change", int'(bus.change), exp_change);
            chk("col_valid", int'(bus.col_valid), exp_valid);
            if (exp_col_chk) chk("col_idx", int'(bus.col_idx), exp_col);
        end
    end

    task automatic drive(input bit r, input bit a, input bit se, input logic [1:0] p,
                         input int xx, input int yy);
        rst           = r;
        bus.arm       = a;
        bus.sample_en = se;
        bus.probe     = p;
        bus.x         = 11'(xx);
        bus.y         = 10'(yy);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] p);
        drive(1'b0, 1'b0, 1'b1, p, 0, 0);
    endtask

    task automatic scan_range(input int x0, input int x1, input int yy);
        for (int xi = x0; xi <= x1; xi++) drive(1'b0, 1'b0, 1'b0, 2'b00, xi, yy);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 2'b00, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 0, 0);
        chk("rst_fsm", int'(bus.fsm), 0);
        chk("rst_valid", int'(bus.col_valid), 0);
        chk("rst_col_idx", int'(bus.col_idx), 0);

        // Early probe changes never trigger
        drive(1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++) wr((i % 2 == 0) ? 2'b01 : 2'b10);
        chk("early_no_trigger", int'(bus.fsm), 1);

        // Reset wins over arm and sample_en
        drive(1'b1, 1'b1, 1'b1, 2'b11, 0, 0);
        chk("rst_priority", int'(bus.fsm), 0);

        // Trigger and hold
        drive(1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        for (int i = 0; i < HALF; i++) wr(2'b00);
        chk("pre_full_armed", int'(bus.fsm), 1);
        wr(2'b01);
        chk("trigger_capture", int'(bus.fsm), 2);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        chk("arm_in_capture", int'(bus.fsm), 2);
        for (int i = 0; i < HALF - 2; i++) wr(2'b01);
        chk("capture_before_last", int'(bus.fsm), 2);
        wr(2'b01);
        chk("hold_after_64", int'(bus.fsm), 3);
        scan_range(0, PX + 31 * BX, 0);
        chk("col31_state", int'(bus.state), 0);
        chk("col31_change", int'(bus.change), 0);
        scan_range(PX + 31 * BX + 1, PX + 32 * BX, 0);
        chk("col32_state", int'(bus.state), 1);
        chk("col32_change", int'(bus.change), 1);
        chk("col32_idx", int'(bus.col_idx), 32);
        scan_range(PX + 32 * BX + 1, XEND - 1, 0);
        chk("col63_valid", int'(bus.col_valid), 1);
        chk("col63_idx", int'(bus.col_idx), 63);
        scan_range(XEND, XEND, 0);
        chk("past_end_valid", int'(bus.col_valid), 0);
        scan_range(XEND + 1, XEND + 5, 0);

        // Blanking row
        scan_range(0, PX + 50, 10'h3FF);
        chk("blank_valid", int'(bus.col_valid), 0);

        // Re-arm from hold while inside the trace area
        scan_range(0, PX + 4, 0);
        chk("hold_valid", int'(bus.col_valid), 1);
        drive(1'b0, 1'b1, 1'b0, 2'b00, PX + 5, 0);
        chk("rearm_fsm", int'(bus.fsm), 1);
        chk("rearm_valid", int'(bus.col_valid), 0);

        // Wrap: 40 pre-trigger writes, trigger, 31 post writes
        for (int i = 0; i < 40; i++) wr((i == 8) ? 2'b11 : 2'b00);
        chk("wrap_armed", int'(bus.fsm), 1);
        wr(2'b01);
        for (int i = 0; i < HALF - 1; i++) wr((i % 2 == 0) ? 2'b10 : 2'b01);
        chk("wrap_hold", int'(bus.fsm), 3);
        scan_range(0, PX, 0);
        chk("wrap_col0_state", int'(bus.state), 3);
        chk("wrap_col0_change", int'(bus.change), 0);
        scan_range(PX + 1, PX + BX, 0);
        chk("wrap_col1_state", int'(bus.state), 0);
        chk("wrap_col1_change", int'(bus.change), 1);
        scan_range(PX + BX + 1, XEND + 3, 0);

        // Reset during capture
        drive(1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        for (int i = 0; i < HALF; i++) wr(2'b00);
        wr(2'b10);
        for (int i = 0; i < 5; i++) wr(2'b11);
        chk("mid_capture", int'(bus.fsm), 2);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 0, 0);
        chk("abort_fsm", int'(bus.fsm), 0);
        chk("abort_state", int'(bus.state), 0);
        chk("abort_change", int'(bus.change), 0);
        chk("abort_valid", int'(bus.col_valid), 0);
        scan_range(0, PX + 30, 0);
        chk("idle_valid", int'(bus.col_valid), 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
